// File: rtl/isqrt_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : isqrt_share_arbiter
//  Purpose  : Shares one pipelined isqrt instance among N_REQ requesters.
//             Each cycle at most one requester is granted. Its operand is
//             forwarded to isqrt, and its index travels down a tag delay line
//             matched to the isqrt latency. That index routes the result back
//             to the requester that issued it.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_REQ          number of requesters (2..8)
//    ISQRT_LATENCY  cycles from isqrt_x_vld to the matching isqrt_y_vld (>=1)
//  Ports
//    clk          in   clock
//    rst          in   synchronous active-high reset
//    req_vld      in   [N_REQ]     per-requester operand valid
//    req_x        in   [N_REQ*32]  packed operands, requester i at [32*i +: 32]
//    req_rdy      out  [N_REQ]     one-hot-or-zero grant
//    resp_vld     out  [N_REQ]     one-hot-or-zero result strobe
//    resp_y       out  [16]        result, shared by all requesters
//    isqrt_x_vld  out  operand valid to isqrt
//    isqrt_x      out  [32]        operand to isqrt
//    isqrt_y_vld  in   result valid from isqrt
//    isqrt_y      in   [16]        result from isqrt
//    tag_err      out  sticky: isqrt_y_vld disagreed with the tag line
//  Build option
//    ISQRT_SHARE_ARBITER_RR_EN  defined   : round-robin arbitration
//                               undefined : fixed priority, lowest index wins
// ============================================================================
module isqrt_share_arbiter #(
    parameter int N_REQ         = 4,
    parameter int ISQRT_LATENCY = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_vld,
    input  logic [N_REQ*32-1:0]  req_x,
    output logic [N_REQ-1:0]     req_rdy,
    output logic [N_REQ-1:0]     resp_vld,
    output logic [15:0]          resp_y,
    output logic                 isqrt_x_vld,
    output logic [31:0]          isqrt_x,
    input  logic                 isqrt_y_vld,
    input  logic [15:0]          isqrt_y,
    output logic                 tag_err
);

    localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic                 w_grant_any;
    logic [c_idx_w-1:0]   w_grant_idx;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ISQRT_SHARE_ARBITER_RR_EN
    logic [c_idx_w-1:0]   ptr_q;
    logic [c_idx_w-1:0]   ptr_d;

    // The search starts at the pointer and wraps modulo N_REQ. The first
    // valid requester found wins.
    always_comb begin
        int j;
        j           = 0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_q) + k) % N_REQ;
            if (!rst && !w_grant_any && req_vld[j]) begin
                w_grant_any = 1'b1;
                w_grant_idx = c_idx_w'(j);
            end
        end
    end

    // The pointer moves only on a transfer, so idle cycles leave it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (w_grant_any) begin
            ptr_d = (int'(w_grant_idx) == N_REQ - 1) ? '0
                                                     : w_grant_idx + c_idx_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: the lowest valid index wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!rst && !w_grant_any && req_vld[k]) begin
                w_grant_any = 1'b1;
                w_grant_idx = c_idx_w'(k);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Grant vector and operand forwarding
    // ------------------------------------------------------------------
    always_comb begin
        req_rdy = '0;
        if (w_grant_any) begin
            req_rdy[w_grant_idx] = 1'b1;
        end
    end

    assign isqrt_x_vld = |(req_vld & req_rdy);

    always_comb begin
        isqrt_x = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_any && (w_grant_idx == c_idx_w'(i))) begin
                isqrt_x = req_x[32*i +: 32];
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag delay line: one stage per isqrt pipeline stage, never stalls.
    // Only the valid bits need a reset. The index bits are ignored while
    // the valid bits are clear.
    // ------------------------------------------------------------------
    logic                 tag_vld_q [ISQRT_LATENCY];
    logic [c_idx_w-1:0]   tag_idx_q [ISQRT_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ISQRT_LATENCY; i++) begin
                tag_vld_q[i] <= 1'b0;
            end
        end else begin
            tag_vld_q[0] <= isqrt_x_vld;
            for (int i = 1; i < ISQRT_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_idx_q[0] <= w_grant_idx;
        for (int i = 1; i < ISQRT_LATENCY; i++) begin
            tag_idx_q[i] <= tag_idx_q[i-1];
        end
    end

    logic                 w_last_vld;
    logic [c_idx_w-1:0]   w_last_idx;

    assign w_last_vld = tag_vld_q[ISQRT_LATENCY-1];
    assign w_last_idx = tag_idx_q[ISQRT_LATENCY-1];

    // ------------------------------------------------------------------
    // Result return and tag consistency check
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]     resp_vld_q;
    logic [15:0]          resp_y_q;
    logic                 tag_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_vld_q <= '0;
            resp_y_q   <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            resp_vld_q <= '0;
            // A result without a valid tag is dropped. It only raises the
            // error flag.
            if (isqrt_y_vld && w_last_vld) begin
                resp_vld_q <= {{(N_REQ-1){1'b0}}, 1'b1} << w_last_idx;
                resp_y_q   <= isqrt_y;
            end
            if (isqrt_y_vld != w_last_vld) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    assign resp_vld = resp_vld_q;
    assign resp_y   = resp_y_q;
    assign tag_err  = tag_err_q;

endmodule
`default_nettype wire

// File: tb/tb_isqrt_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_isqrt_share_arbiter
//  Purpose  : Directed self-checking bench for isqrt_share_arbiter. A
//             behavioural isqrt stub with the default latency sits behind the
//             arbiter. Stray results can be injected into the stub output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_isqrt_share_arbiter;

    localparam int N   = 4;
    localparam int LAT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_vld;
    logic [N*32-1:0]   req_x;
    logic [N-1:0]      req_rdy;
    logic [N-1:0]      resp_vld;
    logic [15:0]       resp_y;
    logic              isqrt_x_vld;
    logic [31:0]       isqrt_x;
    logic              isqrt_y_vld;
    logic [15:0]       isqrt_y;
    logic              tag_err;
    logic              inj;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    isqrt_share_arbiter #(
        .N_REQ         (N),
        .ISQRT_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_x       (req_x),
        .req_rdy     (req_rdy),
        .resp_vld    (resp_vld),
        .resp_y      (resp_y),
        .isqrt_x_vld (isqrt_x_vld),
        .isqrt_x     (isqrt_x),
        .isqrt_y_vld (isqrt_y_vld),
        .isqrt_y     (isqrt_y),
        .tag_err     (tag_err)
    );

    // ---------------- isqrt stub ----------------
    function automatic logic [15:0] sqrt32(input logic [31:0] x);
        logic [63:0] r;
        logic [63:0] t;
        r = 64'd0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[15:0];
    endfunction

    logic        stub_vld [LAT];
    logic [15:0] stub_y   [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stub_vld[i] <= 1'b0;
        end else begin
            stub_vld[0] <= isqrt_x_vld;
            for (int i = 1; i < LAT; i++) stub_vld[i] <= stub_vld[i-1];
        end
        stub_y[0] <= sqrt32(isqrt_x);
        for (int i = 1; i < LAT; i++) stub_y[i] <= stub_y[i-1];
    end

    assign isqrt_y_vld = stub_vld[LAT-1] | inj;
    assign isqrt_y     = stub_y[LAT-1];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst     = 1'b1;
        req_vld = 4'hF;
        req_x   = {32'd16, 32'd9, 32'd4, 32'd1};
        tick;
        tick;
        #1;
        checks++;
        if (req_rdy !== 4'b0000) begin
            errors++; $display("FAIL reset_rdy: got %b expected %b", req_rdy, 4'b0000);
        end
        checks++;
        if (isqrt_x_vld !== 1'b0) begin
            errors++; $display("FAIL reset_x_vld: got %b expected 0", isqrt_x_vld);
        end
        checks++;
        if (resp_vld !== 4'b0000) begin
            errors++; $display("FAIL reset_resp_vld: got %b expected 0000", resp_vld);
        end
        checks++;
        if (resp_y !== 16'd0) begin
            errors++; $display("FAIL reset_resp_y: got %0d expected 0", resp_y);
        end
        checks++;
        if (tag_err !== 1'b0) begin
            errors++; $display("FAIL reset_tag_err: got %b expected 0", tag_err);
        end
        req_vld = 4'h0;
        rst     = 1'b0;
        tick;
    endtask

    task automatic test_single;
        int bad;
        tick;
        req_vld         = 4'b0100;
        req_x[95:64]    = 32'd144;
        #1;
        checks++;
        if (req_rdy !== 4'b0100) begin
            errors++; $display("FAIL single_rdy: got %b expected %b", req_rdy, 4'b0100);
        end
        checks++;
        if (isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd144) begin
            errors++; $display("FAIL single_issue: got vld %b x %0d expected vld 1 x 144", isqrt_x_vld, isqrt_x);
        end
        tick;
        req_vld = 4'b0000;
        bad = 0;
        for (int k = 0; k < 15; k++) begin
            tick;
            if (resp_vld !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL single_early_resp: got %0d early strobes expected 0", bad);
        end
        tick;
        checks++;
        if (resp_vld !== 4'b0100 || resp_y !== 16'd12) begin
            errors++; $display("FAIL single_resp: got vld %b y %0d expected vld 0100 y 12", resp_vld, resp_y);
        end
        tick;
        checks++;
        if (resp_vld !== 4'b0000 || resp_y !== 16'd12) begin
            errors++; $display("FAIL single_hold: got vld %b y %0d expected vld 0000 y 12", resp_vld, resp_y);
        end
    endtask

`ifdef ISQRT_SHARE_ARBITER_RR_EN
    task automatic test_contention;
        logic [3:0] exp_v;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req_vld = 4'hF;
        req_x   = {32'd16, 32'd9, 32'd4, 32'd1};
        #1;
        for (int c = 0; c < 8; c++) begin
            exp_v = 4'(1 << (c % 4));
            checks++;
            if (req_rdy !== exp_v) begin
                errors++; $display("FAIL rr_grant%0d: got %b expected %b", c, req_rdy, exp_v);
            end
            tick;
        end
        req_vld = 4'h0;
        for (int k = 0; k < 9; k++) tick;
        for (int k = 0; k < 8; k++) begin
            exp_v = 4'(1 << (k % 4));
            checks++;
            if (resp_vld !== exp_v || resp_y !== 16'((k % 4) + 1)) begin
                errors++; $display("FAIL rr_resp%0d: got vld %b y %0d expected vld %b y %0d",
                                   k, resp_vld, resp_y, exp_v, (k % 4) + 1);
            end
            tick;
        end
        checks++;
        if (resp_vld !== 4'b0000) begin
            errors++; $display("FAIL rr_drain: got %b expected 0000", resp_vld);
        end
    endtask
`else
    task automatic test_contention;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        req_vld = 4'b1001;
        req_x   = {32'd49, 32'd9, 32'd4, 32'd1};
        #1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (req_rdy !== 4'b0001 || isqrt_x !== 32'd1) begin
                errors++; $display("FAIL fp_grant%0d: got rdy %b x %0d expected rdy 0001 x 1", c, req_rdy, isqrt_x);
            end
            tick;
        end
        req_vld = 4'h0;
        for (int k = 0; k < 11; k++) tick;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (resp_vld !== 4'b0001 || resp_y !== 16'd1) begin
                errors++; $display("FAIL fp_resp%0d: got vld %b y %0d expected vld 0001 y 1", k, resp_vld, resp_y);
            end
            tick;
        end
        checks++;
        if (resp_vld !== 4'b0000) begin
            errors++; $display("FAIL fp_drain: got %b expected 0000", resp_vld);
        end
    endtask
`endif

    task automatic test_back_to_back;
        logic [31:0] xs [3];
        logic [15:0] ys [3];
        xs[0] = 32'd0;          ys[0] = 16'd0;
        xs[1] = 32'hFFFF_FFFF;  ys[1] = 16'd65535;
        xs[2] = 32'd100;        ys[2] = 16'd10;
        tick;
        req_vld = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            req_x[63:32] = xs[c];
            #1;
            checks++;
            if (req_rdy !== 4'b0010 || isqrt_x !== xs[c]) begin
                errors++; $display("FAIL b2b_issue%0d: got rdy %b x %h expected rdy 0010 x %h", c, req_rdy, isqrt_x, xs[c]);
            end
            tick;
        end
        req_vld = 4'b0000;
        for (int k = 0; k < 14; k++) tick;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (resp_vld !== 4'b0010 || resp_y !== ys[k]) begin
                errors++; $display("FAIL b2b_resp%0d: got vld %b y %0d expected vld 0010 y %0d", k, resp_vld, resp_y, ys[k]);
            end
            tick;
        end
        checks++;
        if (resp_vld !== 4'b0000) begin
            errors++; $display("FAIL b2b_drain: got %b expected 0000", resp_vld);
        end
    endtask

    task automatic test_reset_midflight;
        int bad_v;
        int bad_e;
        tick;
        req_vld = 4'b0001; req_x[31:0]  = 32'd4;
        tick;
        req_vld = 4'b0010; req_x[63:32] = 32'd9;
        tick;
        req_vld = 4'b0100; req_x[95:64] = 32'd25;
        tick;
        req_vld = 4'b0000;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bad_v = 0;
        bad_e = 0;
        for (int k = 0; k < 25; k++) begin
            tick;
            if (resp_vld !== 4'b0000) bad_v++;
            if (tag_err !== 1'b0) bad_e++;
        end
        checks++;
        if (bad_v != 0) begin
            errors++; $display("FAIL midrst_resp: got %0d strobes expected 0", bad_v);
        end
        checks++;
        if (bad_e != 0) begin
            errors++; $display("FAIL midrst_tag_err: got %0d cycles set expected 0", bad_e);
        end
        req_vld = 4'hF;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin
            errors++; $display("FAIL midrst_ptr: got %b expected 0001", req_rdy);
        end
        req_vld = 4'h0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_protocol_fault;
        int bad;
        tick;
        inj = 1'b1;
        tick;
        inj = 1'b0;
        checks++;
        if (tag_err !== 1'b1 || resp_vld !== 4'b0000) begin
            errors++; $display("FAIL fault_set: got err %b vld %b expected err 1 vld 0000", tag_err, resp_vld);
        end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick;
            if (tag_err !== 1'b1 || resp_vld !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL fault_hold: got %0d bad cycles expected 0", bad);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (tag_err !== 1'b0) begin
            errors++; $display("FAIL fault_clear: got %b expected 0", tag_err);
        end
    endtask

    initial begin
        rst     = 1'b1;
        inj     = 1'b0;
        req_vld = '0;
        req_x   = '0;
        test_reset;
        test_single;
        test_contention;
        test_back_to_back;
        test_reset_midflight;
        test_protocol_fault;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
